// File: rtl/overlay_compositor_pkg.sv
// Shared constants, wipe state encoding and clamp helpers
// for the emblem overlay path.
package overlay_compositor_pkg;

    localparam logic [5:0] COLOR_TRANSPARENT   = 6'b100001;
    localparam logic [5:0] COLOR_BLACK         = 6'b000000;
    localparam logic [9:0] V_ACTIVE_DEFAULT    = 10'd480;
    localparam logic [9:0] REVEAL_STEP_DEFAULT = 10'd8;

    typedef enum logic [1:0] {
        ST_HIDDEN = 2'd0,
        ST_REVEAL = 2'd1,
        ST_SHOWN  = 2'd2,
        ST_HIDE   = 2'd3
    } wipe_state_t;

    // 11-bit sum so the carry is seen before clamping to lim
    function automatic logic [9:0] sat_add(
        input logic [9:0] a,
        input logic [9:0] b,
        input logic [9:0] lim
    );
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, lim}) ? lim : s[9:0];
    endfunction

    function automatic logic [9:0] floor_sub(
        input logic [9:0] a,
        input logic [9:0] b
    );
        logic [10:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[10] ? 10'd0 : d[9:0];
    endfunction

endpackage

// File: rtl/overlay_compositor_if.sv
// Pixel/sync bundle between the timing/overlay side
// and the compositor.
interface overlay_compositor_if;

    logic       enable;
    logic       hsync_in;
    logic       vsync_in;
    logic       active_in;
    logic [9:0] y_in;
    logic [5:0] bg_rgb;
    logic [5:0] ov_rgb;
    logic [5:0] rgb_out;
    logic       hsync_out;
    logic       vsync_out;
    logic       fully_shown;
    logic [9:0] reveal_line;

    modport master (
        output enable, hsync_in, vsync_in, active_in,
        output y_in, bg_rgb, ov_rgb,
        input  rgb_out, hsync_out, vsync_out,
        input  fully_shown, reveal_line
    );

    modport slave (
        input  enable, hsync_in, vsync_in, active_in,
        input  y_in, bg_rgb, ov_rgb,
        output rgb_out, hsync_out, vsync_out,
        output fully_shown, reveal_line
    );

endinterface

// File: rtl/overlay_compositor_frame_tick_det.sv
// One-cycle pulse on the first low cycle of vsync.
// Shared by the animated overlay blocks.
module frame_tick_det (
    input  logic clk,
    input  logic rst,
    input  logic i_vsync,
    output logic o_tick
);

    logic r_vsync_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_prev <= 1'b1;
        end else begin
            r_vsync_prev <= i_vsync;
        end
    end

    assign o_tick = r_vsync_prev & ~i_vsync;

endmodule

// File: rtl/overlay_compositor.sv
// Composites overlay onto background and runs the
// frame-synchronous top-down reveal / bottom-up hide wipe.
module overlay_compositor
    import overlay_compositor_pkg::*;
#(
    parameter logic [5:0] TRANSPARENT = COLOR_TRANSPARENT,
    parameter logic [9:0] REVEAL_STEP = REVEAL_STEP_DEFAULT,
    parameter logic [9:0] V_ACTIVE    = V_ACTIVE_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    overlay_compositor_if.slave bus
);

    logic        w_tick;
    wipe_state_t r_state;
    logic [9:0]  r_line;
    logic        r_full;
    logic [9:0]  w_add;
    logic [9:0]  w_sub;
    logic [9:0]  w_first;
    logic [9:0]  w_top;
    logic        w_vis;
    logic [5:0]  w_pix;
    logic [5:0]  r_rgb;
    logic        r_hsync;
    logic        r_vsync;

    frame_tick_det u_tick (
        .clk     (clk),
        .rst     (rst),
        .i_vsync (bus.vsync_in),
        .o_tick  (w_tick)
    );

    assign w_add   = sat_add(r_line, REVEAL_STEP, V_ACTIVE);
    assign w_sub   = floor_sub(r_line, REVEAL_STEP);
    assign w_first = sat_add(10'd0, REVEAL_STEP, V_ACTIVE);
    assign w_top   = floor_sub(V_ACTIVE, REVEAL_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HIDDEN;
            r_line  <= 10'd0;
            r_full  <= 1'b0;
        end else if (w_tick) begin
            unique case (r_state)
                ST_HIDDEN: begin
                    if (bus.enable) begin
                        r_state <= ST_REVEAL;
                        r_line  <= w_first;
                    end
                end
                ST_REVEAL: begin
                    if (!bus.enable) begin
                        r_state <= ST_HIDE;
                    end else begin
                        r_line <= w_add;
                        if (w_add == V_ACTIVE) begin
                            r_state <= ST_SHOWN;
                            r_full  <= 1'b1;
                        end
                    end
                end
                ST_SHOWN: begin
                    if (!bus.enable) begin
                        r_state <= ST_HIDE;
                        r_line  <= w_top;
                        r_full  <= 1'b0;
                    end
                end
                ST_HIDE: begin
                    if (bus.enable) begin
                        r_state <= ST_REVEAL;
                    end else begin
                        r_line <= w_sub;
                        if (w_sub == 10'd0) begin
                            r_state <= ST_HIDDEN;
                        end
                    end
                end
            endcase
        end
    end

    assign w_vis = (bus.y_in < r_line);

    always_comb begin
        w_pix = bus.bg_rgb;
        if (!bus.active_in) begin
            w_pix = COLOR_BLACK;
        end else if (w_vis && (bus.ov_rgb != TRANSPARENT)) begin
            w_pix = bus.ov_rgb;
        end
    end

    // Colour and both syncs share one register stage to stay aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb   <= COLOR_BLACK;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_pix;
            r_hsync <= bus.hsync_in;
            r_vsync <= bus.vsync_in;
        end
    end

    assign bus.rgb_out     = r_rgb;
    assign bus.hsync_out   = r_hsync;
    assign bus.vsync_out   = r_vsync;
    assign bus.fully_shown = r_full;
    assign bus.reveal_line = r_line;

endmodule

// File: tb/tb_overlay_compositor.sv
// Directed bench for overlay_compositor: reset, idle, wipe,
// transparency, blanking, reversal, saturation, alignment.
module tb_overlay_compositor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    overlay_compositor_if b8 ();
    overlay_compositor_if b7 ();

    overlay_compositor #(.REVEAL_STEP(10'd8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    overlay_compositor #(.REVEAL_STEP(10'd7)) u7 (
        .clk (clk),
        .rst (rst),
        .bus (b7.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        b8.enable = 0; b8.hsync_in = 1; b8.vsync_in = 1;
        b8.active_in = 1; b8.y_in = 0;
        b8.bg_rgb = 0; b8.ov_rgb = 0;
        b7.enable = 0; b7.hsync_in = 1; b7.vsync_in = 1;
        b7.active_in = 1; b7.y_in = 0;
        b7.bg_rgb = 0; b7.ov_rgb = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    task automatic tick8();
        b8.vsync_in = 0;
        cyc(); cyc();
        b8.vsync_in = 1;
        cyc(); cyc();
    endtask

    task automatic tick7();
        b7.vsync_in = 0;
        cyc(); cyc();
        b7.vsync_in = 1;
        cyc(); cyc();
    endtask

    task automatic test_reset();
        init_inputs();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        b8.hsync_in = 0; b8.vsync_in = 0;
        b8.bg_rgb = 6'b101010;
        cyc(); cyc(); cyc();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (b8.rgb_out !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_rgb: got %b want 000000", b8.rgb_out);
        end
        n_tests++;
        if (b8.hsync_out !== 1'b1 || b8.vsync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sync: got %b%b want 11",
                     b8.hsync_out, b8.vsync_out);
        end
        n_tests++;
        if (b8.fully_shown !== 1'b0 || b8.reveal_line !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_wipe: got %b/%0d want 0/0",
                     b8.fully_shown, b8.reveal_line);
        end
        init_inputs();
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_idle();
        logic [5:0] bg;
        b8.enable = 0;
        b8.ov_rgb = 6'b110000;
        b8.active_in = 1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                bg = 6'(i * 5 + f * 17 + 1);
                b8.bg_rgb = bg;
                b8.y_in = 10'(i);
                cyc();
                n_tests++;
                if (b8.rgb_out !== bg) begin
                    n_fail++;
                    $display("FAIL idle_rgb f%0d i%0d: got %b want %b",
                             f, i, b8.rgb_out, bg);
                end
            end
            tick8();
        end
        n_tests++;
        if (b8.reveal_line !== 10'd0 || b8.fully_shown !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_line: got %0d/%b want 0/0",
                     b8.reveal_line, b8.fully_shown);
        end
    endtask

    task automatic test_reveal();
        b8.enable = 1;
        tick8();
        n_tests++;
        if (b8.reveal_line !== 10'd8) begin
            n_fail++;
            $display("FAIL reveal_t1: got %0d want 8", b8.reveal_line);
        end
        b8.ov_rgb = 6'b110000;
        b8.bg_rgb = 6'b000011;
        b8.active_in = 1;
        b8.y_in = 10'd7;
        cyc();
        n_tests++;
        if (b8.rgb_out !== 6'b110000) begin
            n_fail++;
            $display("FAIL reveal_y7: got %b want 110000", b8.rgb_out);
        end
        b8.y_in = 10'd8;
        cyc();
        n_tests++;
        if (b8.rgb_out !== 6'b000011) begin
            n_fail++;
            $display("FAIL reveal_y8: got %b want 000011", b8.rgb_out);
        end
        for (int k = 2; k <= 60; k++) begin
            tick8();
            n_tests++;
            if (b8.reveal_line !== 10'(8 * k)) begin
                n_fail++;
                $display("FAIL reveal_line t%0d: got %0d want %0d",
                         k, b8.reveal_line, 8 * k);
            end
            n_tests++;
            if (b8.fully_shown !== (k == 60)) begin
                n_fail++;
                $display("FAIL reveal_full t%0d: got %b want %b",
                         k, b8.fully_shown, (k == 60));
            end
        end
    endtask

    task automatic test_transparency();
        b8.active_in = 1;
        b8.y_in = 10'd479;
        b8.ov_rgb = 6'b100001;
        b8.bg_rgb = 6'b000011;
        cyc();
        n_tests++;
        if (b8.rgb_out !== 6'b000011) begin
            n_fail++;
            $display("FAIL transp_key: got %b want 000011", b8.rgb_out);
        end
        b8.ov_rgb = 6'b110000;
        cyc();
        n_tests++;
        if (b8.rgb_out !== 6'b110000) begin
            n_fail++;
            $display("FAIL shown_y479: got %b want 110000", b8.rgb_out);
        end
        b8.active_in = 0;
        for (int i = 0; i < 4; i++) begin
            b8.ov_rgb = (i[0]) ? 6'b100001 : 6'b001100;
            b8.bg_rgb = (i[1]) ? 6'b111111 : 6'b010101;
            b8.y_in = 10'(i * 100);
            cyc();
            n_tests++;
            if (b8.rgb_out !== 6'b000000) begin
                n_fail++;
                $display("FAIL blank %0d: got %b want 000000",
                         i, b8.rgb_out);
            end
        end
        b8.active_in = 1;
    endtask

    task automatic test_reversal();
        do_reset();
        b8.enable = 1;
        for (int k = 1; k <= 25; k++) tick8();
        n_tests++;
        if (b8.reveal_line !== 10'd200) begin
            n_fail++;
            $display("FAIL rev_200: got %0d want 200", b8.reveal_line);
        end
        b8.enable = 0;
        tick8();
        n_tests++;
        if (b8.reveal_line !== 10'd200) begin
            n_fail++;
            $display("FAIL rev_hide: got %0d want 200", b8.reveal_line);
        end
        b8.enable = 1;
        cyc(); cyc();
        b8.enable = 0;
        tick8();
        n_tests++;
        if (b8.reveal_line !== 10'd192) begin
            n_fail++;
            $display("FAIL rev_192: got %0d want 192", b8.reveal_line);
        end
        b8.enable = 1;
        tick8();
        n_tests++;
        if (b8.reveal_line !== 10'd192) begin
            n_fail++;
            $display("FAIL rev_back: got %0d want 192", b8.reveal_line);
        end
        b8.enable = 0;
        cyc();
        b8.enable = 1;
        tick8();
        n_tests++;
        if (b8.reveal_line !== 10'd200) begin
            n_fail++;
            $display("FAIL rev_up: got %0d want 200", b8.reveal_line);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        b7.enable = 1;
        for (int k = 1; k <= 68; k++) tick7();
        n_tests++;
        if (b7.reveal_line !== 10'd476 || b7.fully_shown !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_476: got %0d/%b want 476/0",
                     b7.reveal_line, b7.fully_shown);
        end
        tick7();
        n_tests++;
        if (b7.reveal_line !== 10'd480 || b7.fully_shown !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_480: got %0d/%b want 480/1",
                     b7.reveal_line, b7.fully_shown);
        end
        b7.enable = 0;
        tick7();
        n_tests++;
        if (b7.reveal_line !== 10'd473 || b7.fully_shown !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_473: got %0d/%b want 473/0",
                     b7.reveal_line, b7.fully_shown);
        end
        for (int k = 1; k <= 67; k++) tick7();
        n_tests++;
        if (b7.reveal_line !== 10'd4) begin
            n_fail++;
            $display("FAIL sat_4: got %0d want 4", b7.reveal_line);
        end
        tick7();
        n_tests++;
        if (b7.reveal_line !== 10'd0) begin
            n_fail++;
            $display("FAIL sat_0: got %0d want 0", b7.reveal_line);
        end
        tick7();
        n_tests++;
        if (b7.reveal_line !== 10'd0) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d want 0", b7.reveal_line);
        end
        b7.enable = 1;
        tick7();
        n_tests++;
        if (b7.reveal_line !== 10'd7) begin
            n_fail++;
            $display("FAIL sat_restart: got %0d want 7", b7.reveal_line);
        end
    endtask

    task automatic test_alignment();
        logic hs;
        logic vs;
        int   bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            b8.hsync_in = hs;
            b8.vsync_in = vs;
            cyc();
            n_tests++;
            if (b8.hsync_out !== hs || b8.vsync_out !== vs) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL align %0d: got %b%b want %b%b", i,
                             b8.hsync_out, b8.vsync_out, hs, vs);
            end
        end
        b8.hsync_in = 1;
        b8.vsync_in = 1;
        cyc();
    endtask

    task automatic test_long_vsync();
        do_reset();
        b8.enable = 1;
        b8.vsync_in = 0;
        for (int i = 0; i < 500; i++) cyc();
        b8.vsync_in = 1;
        cyc(); cyc();
        n_tests++;
        if (b8.reveal_line !== 10'd8) begin
            n_fail++;
            $display("FAIL long_vsync: got %0d want 8", b8.reveal_line);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_reveal();
        test_transparency();
        test_reversal();
        test_saturation();
        test_alignment();
        test_long_vsync();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/overlay_compositor.md
# overlay_compositor

Downstream of the emblem overlay generator. Merges the overlay's 6-bit colour (transparent key 6'b100001) onto the background pixel and registers the result with hsync/vsync so all outputs stay aligned. A frame-synchronous state machine reveals the overlay as a top-down wipe and hides it as a bottom-up wipe, so it never tears mid-frame.

## Interface
- `TRANSPARENT`, 6'b100001, overlay colour treated as "no overlay pixel"
- `REVEAL_STEP`, 10'd8, scanlines added or removed per frame during a wipe
- `V_ACTIVE`, 10'd480, visible line count; the wipe saturates here
- `clk` in 1, pixel clock
- `rst` in 1, asynchronous, active-high reset
- `enable` in 1, level request: 1 = overlay shown, 0 = hidden
- `hsync_in` in 1, active-low horizontal sync from the timing generator
- `vsync_in` in 1, active-low vertical sync from the timing generator
- `active_in` in 1, visible-area flag, same cycle as `y_in`
- `y_in` in 10, current scanline
- `bg_rgb` in 6, background colour (RRGGBB)
- `ov_rgb` in 6, overlay generator colour, combinational from the same x/y
- `rgb_out` out 6, registered composited pixel
- `hsync_out` out 1, `hsync_in` delayed to match `rgb_out`
- `vsync_out` out 1, `vsync_in` delayed to match `rgb_out`
- `fully_shown` out 1, registered; high when state == SHOWN
- `reveal_line` out 10, registered wipe boundary

## Operation
- Frame tick: one-cycle internal pulse when the registered `vsync_in` goes 1→0, i.e. the first cycle of the vsync pulse. `vsync_prev` resets to 1.
- State and `reveal_line` change only on a frame tick. `enable` is sampled only on that tick.
- States (2-bit):
  - HIDDEN:
    - tick & enable → REVEAL, with `reveal_line` = min(REVEAL_STEP, V_ACTIVE).
  - REVEAL:
    - tick & !enable → HIDE, line unchanged.
    - tick & enable → `reveal_line` += REVEAL_STEP, saturating at V_ACTIVE.
    - Go to SHOWN on the tick where the sum reaches V_ACTIVE or more.
  - SHOWN:
    - tick & !enable → HIDE, with `reveal_line` = V_ACTIVE − REVEAL_STEP, floored at 0.
  - HIDE:
    - tick & enable → REVEAL, line unchanged.
    - tick & !enable → `reveal_line` −= REVEAL_STEP, floored at 0.
    - Go to HIDDEN on the tick where the result is 0.
- Width rule: compute the sum and difference in 11 bits, then clamp. `reveal_line` never wraps.
- Visibility: `vis = (y_in < reveal_line)`. HIDDEN gives `reveal_line` = 0, so nothing is visible. SHOWN gives V_ACTIVE, so the whole frame is visible.
- Pixel select, priority order:
  - `!active_in` → 6'b000000.
  - Else `vis && ov_rgb != TRANSPARENT` → `ov_rgb`.
  - Else → `bg_rgb`.

## Timing
- Latency: `rgb_out`, `hsync_out` and `vsync_out` are the inputs of cycle n, registered at edge n+1. All three are always mutually aligned.
- `reveal_line`, `fully_shown` and state update on the clock edge after the tick cycle.
- A pixel that is in flight during that edge uses the old `reveal_line`. This is harmless because the tick falls in vertical blanking.
- Reset values:
  - `rgb_out` = 0, `hsync_out` = 1, `vsync_out` = 1.
  - `fully_shown` = 0, `reveal_line` = 0, state = HIDDEN.
- Reset mid-wipe returns to HIDDEN immediately (asynchronous). The next wipe starts from 0.
- `enable` toggling between ticks has no effect. Only its value at the tick matters.
- vsync held low for many cycles gives exactly one tick.

## Structure
- Shared package:
  - `COLOR_TRANSPARENT` and `COLOR_BLACK` constants, already used by the overlay generators.
  - 2-bit state encoding: HIDDEN = 0, REVEAL = 1, SHOWN = 2, HIDE = 3.
  - `V_ACTIVE` default.
- Sub-module `frame_tick_det`: vsync edge detector. The module registers `vsync_in` internally and outputs the tick pulse. Reused by other animated overlays.
- Datapath and FSM live in `overlay_compositor`. Expected size is about 150 lines.

## Test plan
- Reset and idle:
  - Assert `rst` mid-line → outputs immediately read 0/1/1/0/0.
  - With `enable` = 0 for 3 frames → `rgb_out` always equals `bg_rgb` delayed 1 cycle.
- Reveal:
  - Set `enable` = 1 before tick 1, REVEAL_STEP = 8.
  - After tick k, `reveal_line` = 8k.
  - With `ov_rgb` = 6'b110000 and `bg_rgb` = 6'b000011: line 7 shows 110000 after tick 1, line 8 shows 000011.
  - `fully_shown` rises after tick 60.
- Transparency and blanking:
  - In SHOWN, `ov_rgb` = 6'b100001 → `bg_rgb` passes through.
  - `active_in` = 0 → `rgb_out` = 0 whatever the other inputs are.
- Reversal:
  - In REVEAL at `reveal_line` = 200, drop `enable` → next tick enters HIDE with 200, the following tick gives 192.
  - Re-raise `enable` → REVEAL, next tick gives 200.
- Saturation:
  - REVEAL_STEP = 7 → line goes 476 then saturates to 480 and enters SHOWN.
  - On hide it reaches 4, then clamps to 0 and enters HIDDEN.
- Alignment:
  - Random `hsync_in`/`vsync_in` pattern → `hsync_out`/`vsync_out` equal the inputs delayed exactly 1 cycle.
  - A vsync low for 500 cycles produces a single tick.
